// File: rtl/missile_pool_if.sv
// Signal bundle between the game datapath and the missile pool.
// The datapath drives the master side; the pool drives the slave side.
interface missile_pool_if #(
  parameter int N_MISSILES = 8,
  parameter int COORD_W    = 12
);
  logic [COORD_W-1:0]            pixel_row;
  logic [COORD_W-1:0]            pixel_column;
  logic [COORD_W-1:0]            player_row;
  logic [COORD_W-1:0]            player_column;
  logic                          fire;
  logic [N_MISSILES-1:0]         kill;
  logic [N_MISSILES-1:0]         live;
  logic [N_MISSILES*COORD_W-1:0] mis_row_flat;
  logic [N_MISSILES*COORD_W-1:0] mis_col_flat;
  logic [N_MISSILES-1:0]         missile_active;
  logic [3:0]                    missile_output;
  logic                          fire_accepted;
  logic                          fire_dropped;

  modport master (
    output pixel_row, pixel_column, player_row, player_column, fire, kill,
    input  live, mis_row_flat, mis_col_flat, missile_active, missile_output,
           fire_accepted, fire_dropped
  );

  modport slave (
    input  pixel_row, pixel_column, player_row, player_column, fire, kill,
    output live, mis_row_flat, mis_col_flat, missile_active, missile_output,
           fire_accepted, fire_dropped
  );
endinterface

// File: rtl/missile_pool.sv
// Pool of player missiles: launches on fire edges into the lowest free slot,
// moves live missiles upward on a divided tick and retires them at the top or on kill.
module missile_pool #(
  parameter int N_MISSILES     = 8,
  parameter int COORD_W        = 12,
  parameter int TICK_DIV       = 250000,
  parameter int STEP           = 2,
  parameter int COOLDOWN_TICKS = 0,
  parameter int X_OFF          = 15,
  parameter int MIS_W          = 2,
  parameter int MIS_H          = 4
) (
  input  logic          clk,
  input  logic          rst,
  missile_pool_if.slave bus
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CD_W  = $clog2(COOLDOWN_TICKS + 2);

  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(COOLDOWN_TICKS);
  localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] X_OFF_C = COORD_W'(X_OFF);
  localparam logic [COORD_W:0]   MIS_W_C = (COORD_W+1)'(MIS_W);
  localparam logic [COORD_W:0]   MIS_H_C = (COORD_W+1)'(MIS_H);

  logic                  r_fireD;
  logic [CNT_W-1:0]      r_tickCnt;
  logic [CD_W-1:0]       r_cool;
  logic [N_MISSILES-1:0] r_live;
  logic [COORD_W-1:0]    r_row [N_MISSILES];
  logic [COORD_W-1:0]    r_col [N_MISSILES];
  logic                  r_fireAcc;
  logic                  r_fireDrop;

  logic                  w_tick;
  logic                  w_fireReq;
  logic                  w_launch;
  logic                  w_drop;
  logic [N_MISSILES-1:0] w_freeMask;
  logic [N_MISSILES-1:0] w_liveNext;
  logic [N_MISSILES-1:0] w_hit;
  logic [COORD_W-1:0]    w_muzzleCol;
  logic [COORD_W-1:0]    w_rowNext [N_MISSILES];
  logic [COORD_W-1:0]    w_colNext [N_MISSILES];

  assign w_tick      = (r_tickCnt == CNT_MAX);
  assign w_fireReq   = bus.fire & ~r_fireD;
  // Lowest clear bit of live as a one-hot mask; all zero when the pool is full.
  assign w_freeMask  = ~r_live & (r_live + N_MISSILES'(1));
  assign w_launch    = w_fireReq && (r_cool == '0) && (r_live != '1);
  assign w_drop      = w_fireReq && !w_launch;
  assign w_muzzleCol = bus.player_column + X_OFF_C;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fireD    <= 1'b1;
      r_tickCnt  <= '0;
      r_cool     <= '0;
      r_fireAcc  <= 1'b0;
      r_fireDrop <= 1'b0;
    end else begin
      r_fireD    <= bus.fire;
      r_tickCnt  <= w_tick ? '0 : r_tickCnt + CNT_W'(1);
      r_fireAcc  <= w_launch;
      r_fireDrop <= w_drop;
      if (w_launch)
        r_cool <= CD_LOAD;
      else if (w_tick && (r_cool != '0))
        r_cool <= r_cool - CD_W'(1);
    end
  end

  // A launch only targets a slot that was dead at the start of the cycle,
  // so it never competes with kill, retirement or motion on the same slot.
  always_comb begin
    w_liveNext = r_live;
    w_rowNext  = r_row;
    w_colNext  = r_col;
    for (int i = 0; i < N_MISSILES; i++) begin
      if (bus.kill[i] && r_live[i]) begin
        w_liveNext[i] = 1'b0;
      end else if (w_tick && r_live[i] && (r_row[i] < STEP_C)) begin
        w_liveNext[i] = 1'b0;
      end else if (w_tick && r_live[i]) begin
        w_rowNext[i] = r_row[i] - STEP_C;
      end else if (w_launch && w_freeMask[i]) begin
        w_liveNext[i] = 1'b1;
        w_rowNext[i]  = bus.player_row;
        w_colNext[i]  = w_muzzleCol;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live <= '0;
      for (int i = 0; i < N_MISSILES; i++) begin
        r_row[i] <= '0;
        r_col[i] <= '0;
      end
    end else begin
      r_live <= w_liveNext;
      for (int i = 0; i < N_MISSILES; i++) begin
        r_row[i] <= w_rowNext[i];
        r_col[i] <= w_colNext[i];
      end
    end
  end

  // Bounds are widened by one bit so row/col + sprite size cannot wrap near the edge.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_MISSILES; i++) begin
      w_hit[i] = r_live[i]
        && ({1'b0, bus.pixel_row}    >= {1'b0, r_row[i]})
        && ({1'b0, bus.pixel_row}    <  ({1'b0, r_row[i]} + MIS_H_C))
        && ({1'b0, bus.pixel_column} >= {1'b0, r_col[i]})
        && ({1'b0, bus.pixel_column} <  ({1'b0, r_col[i]} + MIS_W_C));
    end
  end

  always_comb begin
    bus.mis_row_flat = '0;
    bus.mis_col_flat = '0;
    for (int i = 0; i < N_MISSILES; i++) begin
      bus.mis_row_flat[i*COORD_W +: COORD_W] = r_row[i];
      bus.mis_col_flat[i*COORD_W +: COORD_W] = r_col[i];
    end
  end

  assign bus.live           = r_live;
  assign bus.missile_active = w_hit;
  assign bus.missile_output = (|w_hit) ? 4'hF : 4'h0;
  assign bus.fire_accepted  = r_fireAcc;
  assign bus.fire_dropped   = r_fireDrop;

endmodule

// File: tb/tb_missile_pool.sv
// Directed bench for missile_pool: dutA runs without cooldown, dutB with a
// two-tick cooldown; both see the same stimulus.
module tb_missile_pool;
  localparam int N  = 4;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          fire;
  logic [N-1:0]  kill;
  logic [CW-1:0] pixRow, pixCol, plRow, plCol;

  int total = 0;
  int bad   = 0;

  logic [3:0] expLive [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
  logic       expAcc  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       expDrop [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  missile_pool_if #(.N_MISSILES(N), .COORD_W(CW)) ifA ();
  missile_pool_if #(.N_MISSILES(N), .COORD_W(CW)) ifB ();

  assign ifA.pixel_row     = pixRow;
  assign ifA.pixel_column  = pixCol;
  assign ifA.player_row    = plRow;
  assign ifA.player_column = plCol;
  assign ifA.fire          = fire;
  assign ifA.kill          = kill;
  assign ifB.pixel_row     = pixRow;
  assign ifB.pixel_column  = pixCol;
  assign ifB.player_row    = plRow;
  assign ifB.player_column = plCol;
  assign ifB.fire          = fire;
  assign ifB.kill          = kill;

  missile_pool #(
    .N_MISSILES(N), .COORD_W(CW), .TICK_DIV(4), .STEP(2),
    .COOLDOWN_TICKS(0), .X_OFF(15), .MIS_W(2), .MIS_H(4)
  ) dutA (.clk(clk), .rst(rst), .bus(ifA));

  missile_pool #(
    .N_MISSILES(N), .COORD_W(CW), .TICK_DIV(4), .STEP(2),
    .COOLDOWN_TICKS(2), .X_OFF(15), .MIS_W(2), .MIS_H(4)
  ) dutB (.clk(clk), .rst(rst), .bus(ifB));

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] slotOf(input logic [N*CW-1:0] flat, input int i);
    return flat[i*CW +: CW];
  endfunction

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reset is released one time unit after a clock edge, so the next edge is E1.
  task automatic doReset();
    rst  = 1'b0;
    fire = 1'b0;
    kill = '0;
    applyStimulus(2);
    rst  = 1'b1;
  endtask

  initial begin
    rst = 1'b1; fire = 1'b1; kill = '0;
    pixRow = '0; pixCol = '0; plRow = '0; plCol = '0;
    #1 rst = 1'b0;
    applyStimulus(2);
    checkOutput("rst_live", ifA.live, 4'b0000);
    checkOutput("rst_rows", ifA.mis_row_flat, '0);
    checkOutput("rst_cols", ifA.mis_col_flat, '0);
    checkOutput("rst_acc", ifA.fire_accepted, 1'b0);
    checkOutput("rst_drop", ifA.fire_dropped, 1'b0);
    rst = 1'b1;
    applyStimulus(2);
    checkOutput("held_fire_live", ifA.live, 4'b0000);
    checkOutput("held_fire_acc", ifA.fire_accepted, 1'b0);
    checkOutput("idle_active", ifA.missile_active, 4'b0000);
    checkOutput("idle_output", ifA.missile_output, 4'h0);

    $display("[TB] single launch and flight");
    plRow = 12'd440; plCol = 12'd305; fire = 1'b0;
    applyStimulus(1);
    fire = 1'b1;
    applyStimulus(1);
    checkOutput("launch_live", ifA.live, 4'b0001);
    checkOutput("launch_acc", ifA.fire_accepted, 1'b1);
    checkOutput("launch_row", slotOf(ifA.mis_row_flat, 0), 12'd440);
    checkOutput("launch_col", slotOf(ifA.mis_col_flat, 0), 12'd320);
    fire = 1'b0;
    applyStimulus(1);
    checkOutput("acc_pulse_end", ifA.fire_accepted, 1'b0);
    applyStimulus(3);
    checkOutput("row_tick1", slotOf(ifA.mis_row_flat, 0), 12'd438);
    applyStimulus(8);
    checkOutput("row_tick3", slotOf(ifA.mis_row_flat, 0), 12'd434);
    pixRow = 12'd435; pixCol = 12'd321; #1;
    checkOutput("hit_active", ifA.missile_active, 4'b0001);
    checkOutput("hit_output", ifA.missile_output, 4'hF);
    pixRow = 12'd434; pixCol = 12'd320; #1;
    checkOutput("hit_corner", ifA.missile_active, 4'b0001);
    pixRow = 12'd438; pixCol = 12'd321; #1;
    checkOutput("miss_row_edge", ifA.missile_active, 4'b0000);
    pixRow = 12'd434; pixCol = 12'd322; #1;
    checkOutput("miss_col_edge", ifA.missile_output, 4'h0);

    $display("[TB] fill pool then overflow");
    doReset();
    plRow = 12'd440; plCol = 12'd305;
    applyStimulus(1);
    for (int p = 0; p < 5; p++) begin
      fire = 1'b1;
      applyStimulus(1);
      checkOutput($sformatf("fill_live%0d", p), ifA.live, expLive[p]);
      checkOutput($sformatf("fill_acc%0d", p), ifA.fire_accepted, expAcc[p]);
      checkOutput($sformatf("fill_drop%0d", p), ifA.fire_dropped, expDrop[p]);
      fire = 1'b0;
      applyStimulus(1);
    end
    checkOutput("drop_pulse_end", ifA.fire_dropped, 1'b0);

    $display("[TB] kill and fire in the same cycle");
    kill = 4'b0010; fire = 1'b1;
    applyStimulus(1);
    checkOutput("kill_live", ifA.live, 4'b1101);
    checkOutput("kill_drop", ifA.fire_dropped, 1'b1);
    checkOutput("kill_acc", ifA.fire_accepted, 1'b0);
    checkOutput("kill_row_hold", slotOf(ifA.mis_row_flat, 1), 12'd438);
    checkOutput("kill_row_other", slotOf(ifA.mis_row_flat, 0), 12'd434);
    kill = '0; fire = 1'b0; plRow = 12'd300; plCol = 12'd100;
    applyStimulus(1);
    fire = 1'b1;
    applyStimulus(1);
    checkOutput("reuse_live", ifA.live, 4'b1111);
    checkOutput("reuse_acc", ifA.fire_accepted, 1'b1);
    checkOutput("reuse_row", slotOf(ifA.mis_row_flat, 1), 12'd300);
    checkOutput("reuse_col", slotOf(ifA.mis_col_flat, 1), 12'd115);
    fire = 1'b0;

    $display("[TB] retire at top of screen");
    doReset();
    plRow = 12'd3; plCol = 12'd305;
    applyStimulus(1);
    fire = 1'b1;
    applyStimulus(1);
    checkOutput("top_launch_row", slotOf(ifA.mis_row_flat, 0), 12'd3);
    fire = 1'b0;
    applyStimulus(2);
    checkOutput("top_row1", slotOf(ifA.mis_row_flat, 0), 12'd1);
    checkOutput("top_live1", ifA.live, 4'b0001);
    applyStimulus(3);
    checkOutput("top_live_before", ifA.live, 4'b0001);
    applyStimulus(1);
    checkOutput("top_retired", ifA.live, 4'b0000);
    plRow = 12'd200; fire = 1'b1;
    applyStimulus(1);
    checkOutput("top_reuse_live", ifA.live, 4'b0001);
    checkOutput("top_reuse_row", slotOf(ifA.mis_row_flat, 0), 12'd200);
    fire = 1'b0;

    $display("[TB] cooldown on dutB");
    doReset();
    plRow = 12'd440; plCol = 12'd305;
    applyStimulus(1);
    fire = 1'b1;
    applyStimulus(1);
    checkOutput("cd_first_acc", ifB.fire_accepted, 1'b1);
    fire = 1'b0;
    applyStimulus(1);
    fire = 1'b1;
    applyStimulus(1);
    checkOutput("cd_drop1", ifB.fire_dropped, 1'b1);
    checkOutput("cd_live1", ifB.live, 4'b0001);
    fire = 1'b0;
    applyStimulus(1);
    fire = 1'b1;
    applyStimulus(1);
    checkOutput("cd_drop2", ifB.fire_dropped, 1'b1);
    fire = 1'b0;
    applyStimulus(2);
    fire = 1'b1;
    applyStimulus(1);
    checkOutput("cd_acc_after", ifB.fire_accepted, 1'b1);
    checkOutput("cd_live_after", ifB.live, 4'b0011);
    fire = 1'b0;

    $display("[TB] asynchronous reset mid-flight");
    #2 rst = 1'b0;
    #1;
    checkOutput("async_liveA", ifA.live, 4'b0000);
    checkOutput("async_rowsA", ifA.mis_row_flat, '0);
    checkOutput("async_colsA", ifA.mis_col_flat, '0);
    checkOutput("async_liveB", ifB.live, 4'b0000);
    fire = 1'b1;
    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(2);
    checkOutput("restart_no_launch", ifA.live, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
